// File: rtl/pio_sequencer.sv
// pio_sequencer: owns the command port of one pio instance.
// Streams the instruction ROM and the config ROM into the pio after reset or on start.
// In RUN it arbitrates host TX pushes against round-robin RX pulls from the four state machines.
// Optional build macro PIO_SEQ_VERIFY_EN adds the prog_crc output (CRC-16/CCITT of loaded words).
module pio_sequencer #(
    parameter int unsigned PROG_LEN   = 32,
    parameter int unsigned CONF_LEN   = 4,
    parameter logic [3:0]  ACT_LOAD   = 4'd1,
    parameter logic [3:0]  ACT_PUSH   = 4'd4,
    parameter logic [3:0]  ACT_PULL   = 4'd5,
    parameter int unsigned PULL_LAT   = 1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [4:0]  conf_addr,
    input  logic [37:0] conf_data,
    output logic [31:0] din,
    output logic [4:0]  index,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    input  logic [31:0] dout,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  rx_empty,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [1:0]  tx_sm,
    input  logic [31:0] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [1:0]  rx_sm,
    output logic [31:0] rx_data,
    output logic        busy,
`ifdef PIO_SEQ_VERIFY_EN
    output logic [15:0] prog_crc,
`endif
    output logic        running
);

    typedef enum logic [2:0] {IDLE, LOAD_PROG, LOAD_CONF, RUN, ABORT} state_t;

    localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
    localparam logic [4:0] CONF_LAST = (CONF_LEN > 0) ? 5'(CONF_LEN - 1) : 5'd0;

    state_t      state;
    state_t      state_next;
    logic        auto_pending;

    // ROM read side: rd_* is the address presented this cycle, pipe_* is the word arriving now
    logic [4:0]  rd_idx;
    logic        rd_act;
    logic [4:0]  rd_last;
    logic [4:0]  pipe_idx;
    logic        pipe_valid;
    logic        entering_load;

    logic [PULL_LAT:0] pull_sh;
    logic [1:0]        pull_sm_sh [PULL_LAT+1];
    logic              inflight;

    logic        hold_valid;
    logic [31:0] hold_data;
    logic [1:0]  hold_sm;

    logic [1:0]  last_pulled;
    logic        grant_pull;
    logic        pull_cand;
    logic [1:0]  cand_sm;
    logic [1:0]  scan_sm;
    logic        push_base;
    logic        push_fire;
    logic        pull_fire;

    logic [3:0]  act_d;
    logic [31:0] din_d;
    logic [4:0]  index_d;
    logic [1:0]  mindex_d;

    assign inflight      = |pull_sh;
    assign rd_last       = (state == LOAD_CONF) ? CONF_LAST : PROG_LAST;
    assign entering_load = (state_next != state) &&
                           ((state_next == LOAD_PROG) || (state_next == LOAD_CONF));
    assign rx_valid      = hold_valid;
    assign rx_data       = hold_data;
    assign rx_sm         = hold_sm;

    // state register; auto_pending makes the first edge after reset release start a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
        end else begin
            state        <= state_next;
            auto_pending <= 1'b0;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start || auto_pending) state_next = LOAD_PROG;
            LOAD_PROG: if (pipe_valid && (pipe_idx == PROG_LAST))
                           state_next = (CONF_LEN == 0) ? RUN : LOAD_CONF;
            LOAD_CONF: if (pipe_valid && (pipe_idx == CONF_LAST)) state_next = RUN;
            RUN:       if (start) state_next = inflight ? ABORT : LOAD_PROG;
            ABORT:     if (!inflight) state_next = LOAD_PROG;
            default:   state_next = IDLE;
        endcase
    end

    // ROM address sequencing for both load phases, with a one-cycle data pipeline behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx     <= '0;
            rd_act     <= 1'b0;
            pipe_idx   <= '0;
            pipe_valid <= 1'b0;
        end else begin
            pipe_valid <= rd_act;
            pipe_idx   <= rd_idx;
            if (entering_load) begin
                rd_idx <= '0;
                rd_act <= 1'b1;
            end else if (rd_act) begin
                if (rd_idx == rd_last) rd_act <= 1'b0;
                else                   rd_idx <= rd_idx + 5'd1;
            end
        end
    end

    // round-robin scan for the first non-empty RX FIFO after the last one pulled
    always_comb begin
        pull_cand = 1'b0;
        cand_sm   = '0;
        scan_sm   = '0;
        if ((state == RUN) && !start && !hold_valid && !inflight) begin
            for (int unsigned i = 1; i <= 4; i++) begin
                scan_sm = last_pulled + 2'(i);
                if (!pull_cand && !rx_empty[scan_sm]) begin
                    pull_cand = 1'b1;
                    cand_sm   = scan_sm;
                end
            end
        end
    end

    // output decode: status, ROM addresses, push/pull arbitration and the next command
    always_comb begin
        busy      = (state == LOAD_PROG) || (state == LOAD_CONF);
        running   = (state == RUN);
        prog_addr = (state == LOAD_PROG) ? rd_idx : '0;
        conf_addr = (state == LOAD_CONF) ? rd_idx : '0;
        push_base = (state == RUN) && !start && !tx_full[tx_sm] && !inflight;
        tx_ready  = push_base && (!grant_pull || !pull_cand);
        push_fire = tx_valid && tx_ready;
        pull_fire = pull_cand && !push_fire;
        act_d     = '0;
        din_d     = '0;
        index_d   = '0;
        mindex_d  = '0;
        case (state)
            LOAD_PROG: if (pipe_valid) begin
                act_d   = ACT_LOAD;
                index_d = pipe_idx;
                din_d   = {16'h0000, prog_data};
            end
            LOAD_CONF: if (pipe_valid) begin
                act_d    = conf_data[35:32];
                mindex_d = conf_data[37:36];
                din_d    = conf_data[31:0];
                index_d  = pipe_idx;
            end
            RUN: begin
                if (push_fire) begin
                    act_d    = ACT_PUSH;
                    mindex_d = tx_sm;
                    din_d    = tx_data;
                end else if (pull_fire) begin
                    act_d    = ACT_PULL;
                    mindex_d = cand_sm;
                end
            end
            default: ;
        endcase
    end

    // registered command port; action falls back to 0 whenever nothing is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            action <= '0;
            din    <= '0;
            index  <= '0;
            mindex <= '0;
        end else begin
            action <= act_d;
            din    <= din_d;
            index  <= index_d;
            mindex <= mindex_d;
        end
    end

    // grant pointer flips to the other requester after each service; remembers last pulled sm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_pull  <= 1'b0;
            last_pulled <= '0;
        end else begin
            if (push_fire)      grant_pull <= 1'b1;
            else if (pull_fire) grant_pull <= 1'b0;
            if (pull_fire) last_pulled <= cand_sm;
        end
    end

    // pull latency tracker and RX holding register (survives reloads)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pull_sh    <= '0;
            for (int unsigned i = 0; i <= PULL_LAT; i++) pull_sm_sh[i] <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_sm    <= '0;
        end else begin
            pull_sh       <= {pull_sh[PULL_LAT-1:0], pull_fire};
            pull_sm_sh[0] <= cand_sm;
            for (int unsigned i = 1; i <= PULL_LAT; i++) pull_sm_sh[i] <= pull_sm_sh[i-1];
            if (pull_sh[PULL_LAT]) begin
                hold_valid <= 1'b1;
                hold_data  <= dout;
                hold_sm    <= pull_sm_sh[PULL_LAT];
            end else if (hold_valid && rx_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

`ifdef PIO_SEQ_VERIFY_EN
    logic [15:0] crc_run;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 16; i++) begin
            if (c[15] ^ data[15-i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                    c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // running CRC over each ACT_LOAD word; published when LOAD_PROG completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_run  <= 16'hFFFF;
            prog_crc <= '0;
        end else if ((state != LOAD_PROG) && (state_next == LOAD_PROG)) begin
            crc_run <= 16'hFFFF;
        end else if ((state == LOAD_PROG) && pipe_valid) begin
            crc_run <= crc16_step(crc_run, prog_data);
            if (state_next != LOAD_PROG) prog_crc <= crc16_step(crc_run, prog_data);
        end
    end
`endif

endmodule

// File: tb/tb_pio_sequencer.sv
// tb_pio_sequencer: directed bench for pio_sequencer with ROM and dout models.
module tb_pio_sequencer;

    localparam logic [3:0] ACT_LOAD = 4'd1;
    localparam logic [3:0] ACT_CONF = 4'd2;
    localparam logic [3:0] ACT_PUSH = 4'd4;
    localparam logic [3:0] ACT_PULL = 4'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data = '0;
    logic [4:0]  conf_addr;
    logic [37:0] conf_data = '0;
    logic [31:0] din;
    logic [4:0]  index;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [31:0] dout = 32'h1111_0000;
    logic [3:0]  tx_full;
    logic [3:0]  rx_empty;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_sm;
    logic [31:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  rx_sm;
    logic [31:0] rx_data;
    logic        busy;
    logic        running;
`ifdef PIO_SEQ_VERIFY_EN
    logic [15:0] prog_crc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // synchronous ROMs and a pio dout that changes every cycle
    always @(posedge clk) prog_data <= 16'hA000 + {11'b0, prog_addr};
    always @(posedge clk) conf_data <= {conf_addr[1:0], 4'd2, 32'hC0F0_0000 + {27'b0, conf_addr}};
    always @(posedge clk) dout <= dout + 32'h0101_0101;

    pio_sequencer #(
        .PROG_LEN(32), .CONF_LEN(4), .ACT_LOAD(4'd1), .ACT_PUSH(4'd4),
        .ACT_PULL(4'd5), .PULL_LAT(1), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .conf_addr(conf_addr), .conf_data(conf_data),
        .din(din), .index(index), .action(action), .mindex(mindex),
        .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sm(tx_sm), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_sm(rx_sm), .rx_data(rx_data),
        .busy(busy),
`ifdef PIO_SEQ_VERIFY_EN
        .prog_crc(prog_crc),
`endif
        .running(running)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (action !== 4'd0) begin errors++; $display("FAIL reset_action: got %0d want 0", action); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h want 0", din); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bit found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (action === ACT_LOAD && index === 5'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midload_reach: index 10 never loaded within 100 cycles");
        end else if (din !== 32'h0000_A00A) begin
            errors++; $display("FAIL midload_din: got %h want 0000a00a", din);
        end
        reset = 1'b1;
        #1;
        checks++; if (action !== 4'd0) begin errors++; $display("FAIL async_reset_action: got %0d want 0", action); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        checks++; if (index !== 5'd0 || din !== 32'h0) begin
            errors++; $display("FAIL async_reset_fields: index=%0d din=%h want 0/0", index, din);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // called right after reset release: cycle 0 is the first cycle in LOAD_PROG
    task automatic test_load_and_config();
        int nload = 0;
        int nconf = 0;
        int conf_first = 0;
        bit done = 1'b0;
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b want 1", busy); end
            end
            if (action === ACT_LOAD) begin
                checks++;
                if (index !== 5'(nload) || din !== {16'h0, 16'hA000 + 16'(nload)} ||
                    mindex !== 2'd0 || cyc != 2 + nload) begin
                    errors++;
                    $display("FAIL load_word: index=%0d din=%h mindex=%0d cyc=%0d want index=%0d din=%h mindex=0 cyc=%0d",
                             index, din, mindex, cyc, nload, {16'h0, 16'hA000 + 16'(nload)}, 2 + nload);
                end
                nload++;
            end else if (action === ACT_CONF) begin
                if (nconf == 0) begin
                    conf_first = cyc;
                    checks++; if (running !== 1'b0) begin errors++; $display("FAIL conf_running_early: got %b want 0", running); end
                end
                checks++;
                if (nload != 32 || mindex !== 2'(nconf) || din !== 32'hC0F0_0000 + 32'(nconf) ||
                    cyc != conf_first + nconf) begin
                    errors++;
                    $display("FAIL conf_entry: mindex=%0d din=%h cyc=%0d loads=%0d want mindex=%0d din=%h cyc=%0d loads=32",
                             mindex, din, cyc, nload, nconf, 32'hC0F0_0000 + 32'(nconf), conf_first + nconf);
                end
                nconf++;
                if (nconf == 4) done = 1'b1;
            end else if (action !== 4'd0) begin
                checks++; errors++;
                $display("FAIL load_stray_action: got %0d want 0 at cyc %0d", action, cyc);
            end
        end
        checks++;
        if (nload != 32 || nconf != 4) begin
            errors++; $display("FAIL load_counts: loads=%0d confs=%0d want 32/4", nload, nconf);
        end
        @(negedge clk);
        checks++; if (action !== 4'd0) begin errors++; $display("FAIL conf_after_action: got %0d want 0", action); end
        checks++; if (running !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL run_entry: running=%b busy=%b want 1/0", running, busy);
        end
    endtask

    task automatic test_push_backpressure();
        @(negedge clk);
        tx_sm = 2'd2; tx_full = 4'b0100; tx_data = 32'hDEAD_BEEF; tx_valid = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL push_full_ready: got %b want 0", tx_ready); end
        @(negedge clk);
        checks++; if (action !== 4'd0) begin errors++; $display("FAIL push_full_action: got %0d want 0", action); end
        tx_full = 4'b0000;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL push_ready: got %b want 1", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (action !== ACT_PUSH || mindex !== 2'd2 || din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL push_issue: action=%0d mindex=%0d din=%h want 4/2/deadbeef", action, mindex, din);
        end
        @(negedge clk);
        checks++; if (action !== 4'd0) begin errors++; $display("FAIL push_once: got %0d want 0", action); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_sm [3] = '{2'd1, 2'd3, 2'd1};
        logic [31:0] qd[$];
        logic [1:0]  qs[$];
        logic [31:0] ed;
        logic [1:0]  es;
        int npull = 0;
        int nrx = 0;
        bit cap_pending = 1'b0;
        logic [1:0] cap_sm = '0;
        rx_ready = 1'b1;
        rx_empty = 4'b0101;
        for (int cyc = 0; cyc < 60 && nrx < 3; cyc++) begin
            @(negedge clk);
            if (cap_pending) begin
                qd.push_back(dout); qs.push_back(cap_sm); cap_pending = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                checks++;
                if (qd.size() == 0) begin
                    errors++; $display("FAIL rr_rx_unexpected: rx_valid with no pull pending");
                end else begin
                    ed = qd.pop_front(); es = qs.pop_front();
                    if (rx_data !== ed || rx_sm !== es) begin
                        errors++; $display("FAIL rr_rx_data: data=%h sm=%0d want data=%h sm=%0d", rx_data, rx_sm, ed, es);
                    end
                end
                nrx++;
                if (nrx == 3) rx_empty = 4'b1111;
            end
            if (action === ACT_PULL) begin
                checks++;
                if (npull >= 3) begin
                    errors++; $display("FAIL rr_extra_pull: pull %0d from sm%0d want none", npull, mindex);
                end else begin
                    if (mindex !== exp_sm[npull]) begin
                        errors++; $display("FAIL rr_order: pull %0d sm=%0d want sm=%0d", npull, mindex, exp_sm[npull]);
                    end
                    cap_sm = exp_sm[npull];
                end
                cap_pending = 1'b1;
                npull++;
            end else if (action !== 4'd0) begin
                checks++; errors++; $display("FAIL rr_stray_action: got %0d want 0 or 5", action);
            end
        end
        checks++; if (npull != 3 || nrx != 3) begin errors++; $display("FAIL rr_counts: pulls=%0d words=%0d want 3/3", npull, nrx); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || action !== 4'd0) begin
            errors++; $display("FAIL rr_quiet: rx_valid=%b action=%0d want 0/0", rx_valid, action);
        end
    endtask

    task automatic test_contention();
        int nissue = 0;
        logic [3:0] want;
        @(negedge clk);
        tx_sm = 2'd0; tx_data = 32'h1234_5678; tx_full = 4'b0000;
        rx_empty = 4'b1110; rx_ready = 1'b1; tx_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && nissue < 6; cyc++) begin
            @(negedge clk);
            if (action !== 4'd0) begin
                want = (nissue % 2 == 0) ? ACT_PUSH : ACT_PULL;
                checks++;
                if (action !== want || mindex !== 2'd0 ||
                    (want == ACT_PUSH && din !== 32'h1234_5678)) begin
                    errors++; $display("FAIL contend_issue %0d: action=%0d mindex=%0d din=%h want action=%0d mindex=0",
                                       nissue, action, mindex, din, want);
                end
                nissue++;
            end
        end
        checks++; if (nissue != 6) begin errors++; $display("FAIL contend_count: issues=%0d want 6", nissue); end
        tx_valid = 1'b0;
        rx_empty = 4'b1111;
        repeat (8) @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || action !== 4'd0) begin
            errors++; $display("FAIL contend_drain: rx_valid=%b action=%0d want 0/0", rx_valid, action);
        end
    endtask

    task automatic test_abort_reload();
        bit found = 1'b0;
        logic [31:0] exp_data;
        int nload = 0;
        bit done = 1'b0;
        rx_ready = 1'b0;
        rx_empty = 4'b1101;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (action === ACT_PULL) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL abort_pull_reach: no pull within 20 cycles");
        end else if (mindex !== 2'd1) begin
            errors++; $display("FAIL abort_pull_sm: got %0d want 1", mindex);
        end
        start = 1'b1;
        rx_empty = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        exp_data = dout;
        for (int cyc = 0; cyc < 150 && !done; cyc++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp_data || rx_sm !== 2'd1) begin
                errors++; $display("FAIL abort_hold: valid=%b data=%h sm=%0d want 1/%h/1", rx_valid, rx_data, rx_sm, exp_data);
            end
            if (action === ACT_LOAD) begin
                checks++;
                if (index !== 5'(nload)) begin
                    errors++; $display("FAIL reload_index: got %0d want %0d", index, nload);
                end
                nload++;
            end
            if (nload == 32 && running === 1'b1) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL reload_done: loads=%0d running=%b want 32/1", nload, running); end
        rx_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_drain: rx_valid=%b want 0", rx_valid); end
    endtask

    // start with nothing in flight drops tx_ready at once; a start during the load is ignored
    task automatic test_start_in_run();
        int nload = 0;
        bit done = 1'b0;
        tx_sm = 2'd0; tx_full = 4'b0000;
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL start_pre_ready: got %b want 1", tx_ready); end
        start = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL start_drop_ready: got %b want 0", tx_ready); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
        for (int cyc = 0; cyc < 150 && !done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (action === ACT_LOAD) begin
                checks++;
                if (index !== 5'(nload)) begin
                    errors++; $display("FAIL ignore_start_index: got %0d want %0d", index, nload);
                end
                nload++;
                if (nload == 5) start = 1'b1;
            end
            if (nload == 32 && running === 1'b1) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL ignore_start_done: loads=%0d running=%b want 32/1", nload, running); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tx_valid = 1'b0; tx_sm = '0; tx_data = '0;
        tx_full = '0; rx_empty = '1; rx_ready = 1'b0;
        test_reset();
        test_reset_mid_load();
        test_load_and_config();
        test_push_backpressure();
        test_round_robin();
        test_contention();
        test_abort_reload();
        test_start_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pio_sequencer.md
Name: pio_sequencer

Overview:
Controller that owns the command port of one pio instance. After reset or on demand it streams the instruction memory and the configuration list into the PIO. It then arbitrates runtime traffic between a host TX push stream and round-robin RX draining of the four state machines. It replaces ad-hoc loader logic in top-level designs and sits directly between the program/config ROMs, the host logic and pio.

Parameters:
PROG_LEN, 32, number of instruction words loaded (1..32); index runs 0..PROG_LEN-1
CONF_LEN, 4, number of config entries issued (0..32)
ACT_LOAD, 4'd1, action code for an instruction write
ACT_PUSH, 4'd4, action code for a TX FIFO push
ACT_PULL, 4'd5, action code for an RX FIFO pull
PULL_LAT, 1, cycles from a pull action to dout valid (1..3)
AUTO_START, 1, 1 = begin loading immediately after reset; 0 = wait for start

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: (re)load program and config; honoured in IDLE or RUN
prog_addr  out  5  instruction ROM address; synchronous ROM, 1-cycle read latency
prog_data  in  16  instruction ROM data
conf_addr  out  5  config ROM address; 1-cycle read latency
conf_data  in  38  config entry: [37:36] mindex, [35:32] action, [31:0] din
din  out  32  to pio din
index  out  5  to pio index
action  out  4  to pio action
mindex  out  2  to pio mindex
dout  in  32  from pio dout
tx_full  in  4  from pio
rx_empty  in  4  from pio
tx_valid / tx_ready  in / out  1 / 1  host push handshake
tx_sm  in  2  target state machine for the push
tx_data  in  32  push word
rx_valid / rx_ready  out / in  1 / 1  pulled word handshake
rx_sm  out  2  source state machine of rx_data
rx_data  out  32  pulled word
busy  out  1  high in LOAD_PROG and LOAD_CONF
running  out  1  high in RUN

Behaviour:
- Reset (async): all outputs 0; state IDLE, or LOAD_PROG on the first clock edge after reset release when AUTO_START=1.
- The action output is a one-cycle command. It returns to 0 in every cycle with no issue.
- LOAD_PROG: ROM address leads by one cycle. One ACT_LOAD per cycle with index=k, din={16'b0,prog_data}, mindex=0 for k=0..PROG_LEN-1.
- Exact sequence: PROG_LEN consecutive ACT_LOAD cycles. The first one occurs 2 cycles after entering LOAD_PROG.
- LOAD_CONF: one issue per cycle of conf_data fields, CONF_LEN entries, same one-cycle ROM lead. If CONF_LEN=0, go directly to RUN.
- RUN: tx_ready = !tx_full[tx_sm] and no pull in flight and (grant==PUSH or no pull candidate).
- Push: on tx_valid&tx_ready, issue action=ACT_PUSH, mindex=tx_sm, din=tx_data in the next cycle.
- Pull candidate: the first sm with !rx_empty, scanned round-robin from last_pulled+1. A candidate only exists when the rx holding register is empty.
- Pull: issue ACT_PULL, mindex=sm. Capture dout exactly PULL_LAT cycles later into rx_data/rx_sm and assert rx_valid. rx_valid stays high until rx_ready; rx_data must stay stable while rx_valid is high.
- Arbitration: when push and pull are both eligible in the same cycle, the grant alternates. After reset the first grant goes to push. At most one action per cycle.
- start in RUN: abort. Drop tx_ready immediately, let any in-flight pull complete into the holding register, then go to LOAD_PROG. The holding register is kept; rx_valid persists.
- start during LOAD_PROG or LOAD_CONF is ignored.
- tx_full or rx_empty changing during an issued action has no effect on that action.

Optional Feature:
PIO_SEQ_VERIFY_EN: adds output prog_crc[15:0], a CRC-16/CCITT (init 16'hFFFF) over the words issued in LOAD_PROG. It is updated once per ACT_LOAD, latched at LOAD_PROG exit and cleared on reset. Without the macro, prog_crc is absent and no CRC logic is synthesised.

Test Plan:
- Load: AUTO_START=1, PROG_LEN=32, ROM word k=16'hA000+k -> exactly 32 ACT_LOAD cycles; index k carries din=0000A00k..; running rises after the last CONF_LEN entry.
- Config: CONF_LEN=4, entries with mindex 0..3 and action 2 -> 4 consecutive issues with matching fields; action=0 afterwards.
- Push backpressure: tx_sm=2, tx_full=4'b0100 -> tx_ready=0; clear bit 2 -> one ACT_PUSH with mindex=2, din=tx_data=32'hDEADBEEF.
- Round-robin pull: rx_empty=4'b0101 (sm1 and sm3 ready), rx_ready=1 -> pulls alternate sm1, sm3, sm1; rx_data equals dout sampled PULL_LAT cycles after each pull.
- Contention: tx_valid held high and sm0 never empty -> issues alternate PUSH, PULL, PUSH; no cycle carries two actions.
- Reset and reload: assert reset mid-LOAD_PROG at index 10 -> outputs 0 immediately; reload restarts at index 0. start in RUN with rx_valid high and rx_ready=0 -> word retained, reload proceeds.
